hamming_flit_decoder: RTL
=========================

# hamming_flit_decoder

Receives the 7-bit Hamming(7,4) codeword and the 4-bit address that the input processing stage emits on separate channels after splitting each 11-bit flit. It joins them, corrects any single-bit error, and presents a decoded 4-bit data + 4-bit address word to the router core through a 2-stage valid/ready pipeline. It also keeps statistics counters for corrected and total flits.

## Interface
Parameters:
- CNT_W, 8: width of the saturating corrected-flit counter.
- TOT_W, 16: width of the wrapping total-flit counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data_valid  in  1  codeword channel valid.
- in_data  in  7  Hamming(7,4) codeword.
- in_data_ready  out  1  codeword channel ready.
- in_addr_valid  in  1  address channel valid.
- in_addr  in  4  destination address.
- in_addr_ready  out  1  address channel ready.
- out_valid  out  1  decoded flit valid.
- out_ready  in  1  downstream ready.
- out_data  out  4  corrected data nibble.
- out_addr  out  4  address carried with the flit.
- out_corrected  out  1  a single-bit error was corrected in this flit.
- clear_counts  in  1  synchronous counter clear pulse.
- corr_count  out  CNT_W  number of corrected flits delivered, saturating.
- tot_count  out  TOT_W  number of flits delivered, wrapping.

## Operation
- Join: an input transfer happens only when both in_data_valid and in_addr_valid are high and stage 1 can accept.
  - in_data_ready = in_addr_valid & s1_ready.
  - in_addr_ready = in_data_valid & s1_ready.
  - Both channels are consumed in the same cycle. A lone valid is never consumed.
- Stage 1 registers the codeword and address.
- Stage 2 registers the decode result.
- Each stage follows the rule: s_ready = !s_valid | next_ready. out_ready is the next_ready for stage 2.
- Bit map: codeword bit i is Hamming position i+1.
  - Parity bits p1, p2, p4 are bits 0, 1, 3.
  - Data bits d1, d2, d3, d4 are bits 2, 4, 5, 6.
- Syndrome S = {s4, s2, s1}:
  - s1 = b0^b2^b4^b6
  - s2 = b1^b2^b5^b6
  - s4 = b3^b4^b5^b6
- If S≠0, bit S−1 is inverted and out_corrected=1. If S=0, no change and out_corrected=0.
- out_data = {b6, b5, b4, b2} of the corrected word. A parity-bit error (S = 1, 2 or 4) sets out_corrected but leaves the data unchanged.
- Double errors are not detected. They decode as a miscorrection; this is accepted behaviour.
- Counters update on an output transfer (out_valid & out_ready):
  - tot_count increments by 1, wrapping at 2^TOT_W.
  - corr_count increments by 1 if out_corrected, holding at 2^CNT_W−1.
- clear_counts sets both counters to 0. It takes priority over an increment in the same cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_addr=0, out_corrected=0, corr_count=0, tot_count=0, all internal valids 0.
- Ready outputs after reset are combinational: each is high once the other channel's valid is high.
- Latency: an input transfer in cycle N gives out_valid=1 in cycle N+2.
- Throughput: 1 flit/cycle while out_ready stays high.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data, out_addr and out_corrected hold stable.
  - Stage 1 may still fill once more.
  - The inputs stall after that, so at most 2 flits are buffered and none are dropped or duplicated.
- Full pipeline, then out_ready rises: both stages advance in the same cycle, and a new input is accepted in that cycle.
- Asynchronous reset mid-operation: all buffered flits are discarded and outputs return to reset values immediately. No transfer is counted in a cycle where rst_n is low.
- Ordering is strictly FIFO, and each address stays paired with the codeword it was joined with.

## Test plan
- Clean flit: in_data=7'h55, in_addr=4'h3, out_ready=1 → 2 cycles later out_data=4'hB, out_addr=4'h3, out_corrected=0; tot_count=1, corr_count=0.
- Single data-bit error: in_data=7'h45 (bit 4 flipped from 7'h55), in_addr=4'hA → out_data=4'hB, out_corrected=1, corr_count increments. Repeat for each of the 7 bit positions; data stays 4'hB every time.
- Join skew: in_data_valid high 3 cycles before in_addr_valid → no transfer and in_data_ready=0 until in_addr_valid rises; exactly one flit is output.
- Backpressure: stream 6 random flits with out_ready toggling on a pseudo-random pattern → output sequence matches the scoreboard exactly; outputs are stable while stalled; at most 2 flits are accepted beyond the last delivered one.
- Counters: 300 corrected flits → corr_count=255 (saturated), tot_count=300. clear_counts in the same cycle as a transfer → both counters read 0 the next cycle.
- Reset mid-stream: assert rst_n=0 with both stages full → out_valid=0 immediately. After release, the next input emerges with 2-cycle latency and no stale flit appears.

Source files
------------

// File: rtl/hamming_flit_decoder_if.sv
// Handshake and status bundle between the flit splitter, the decoder and the router core.
// The master drives the codeword/address channels; the slave is the decoder itself.
interface hamming_flit_decoder_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TOT_W = 16
) ();

  logic             in_data_valid;
  logic [6:0]       in_data;
  logic             in_data_ready;
  logic             in_addr_valid;
  logic [3:0]       in_addr;
  logic             in_addr_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [3:0]       out_addr;
  logic             out_corrected;
  logic             clear_counts;
  logic [CNT_W-1:0] corr_count;
  logic [TOT_W-1:0] tot_count;

  modport master (
    output in_data_valid, in_data, in_addr_valid, in_addr, out_ready, clear_counts,
    input  in_data_ready, in_addr_ready, out_valid, out_data, out_addr, out_corrected,
           corr_count, tot_count
  );

  modport slave (
    input  in_data_valid, in_data, in_addr_valid, in_addr, out_ready, clear_counts,
    output in_data_ready, in_addr_ready, out_valid, out_data, out_addr, out_corrected,
           corr_count, tot_count
  );

endinterface

// File: rtl/hamming_flit_decoder.sv
// Joins codeword and address channels, corrects single-bit Hamming(7,4) errors and delivers
// data+address through a two-stage valid/ready pipeline with delivered/corrected counters.
module hamming_flit_decoder #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TOT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  hamming_flit_decoder_if.slave flit_io
);

  // Stage 1: raw codeword and address as joined from the two channels.
  logic       s1_valid_q, s1_valid_d;
  logic [6:0] s1_code_q, s1_code_d;
  logic [3:0] s1_addr_q, s1_addr_d;

  // Stage 2: decoded result presented to the router core.
  logic       s2_valid_q, s2_valid_d;
  logic [3:0] s2_data_q, s2_data_d;
  logic [3:0] s2_addr_q, s2_addr_d;
  logic       s2_corr_q, s2_corr_d;

  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [TOT_W-1:0] tot_cnt_q, tot_cnt_d;

  logic       s1_ready;
  logic       s2_ready;
  logic       in_fire;
  logic       out_fire;

  logic [2:0] syndrome;
  logic [6:0] flip_mask;
  logic [6:0] code_fixed;
  logic [3:0] dec_data;
  logic       dec_corr;

  // Handshake
  assign s2_ready = ~s2_valid_q | flit_io.out_ready;
  assign s1_ready = ~s1_valid_q | s2_ready;
  assign in_fire  = flit_io.in_data_valid & flit_io.in_addr_valid & s1_ready;
  assign out_fire = s2_valid_q & flit_io.out_ready;

  // Each channel's ready depends on the other's valid so a lone valid is never consumed.
  assign flit_io.in_data_ready = flit_io.in_addr_valid & s1_ready;
  assign flit_io.in_addr_ready = flit_io.in_data_valid & s1_ready;

  // Decode of the stage-1 codeword; bit i is Hamming position i+1.
  always_comb begin
    syndrome[0] = s1_code_q[0] ^ s1_code_q[2] ^ s1_code_q[4] ^ s1_code_q[6];
    syndrome[1] = s1_code_q[1] ^ s1_code_q[2] ^ s1_code_q[5] ^ s1_code_q[6];
    syndrome[2] = s1_code_q[3] ^ s1_code_q[4] ^ s1_code_q[5] ^ s1_code_q[6];

    flip_mask = '0;
    for (int i = 0; i < 7; i++) begin
      if (syndrome == 3'(i + 1)) begin
        flip_mask[i] = 1'b1;
      end
    end

    code_fixed = s1_code_q ^ flip_mask;
    dec_data   = {code_fixed[6], code_fixed[5], code_fixed[4], code_fixed[2]};
    dec_corr   = |syndrome;
  end

  // Pipeline next state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_addr_d  = s1_addr_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_addr_d  = s2_addr_q;
    s2_corr_d  = s2_corr_q;

    if (s1_ready) begin
      s1_valid_d = in_fire;
      if (in_fire) begin
        s1_code_d = flit_io.in_data;
        s1_addr_d = flit_io.in_addr;
      end
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = dec_data;
        s2_addr_d = s1_addr_q;
        s2_corr_d = dec_corr;
      end
    end
  end

  // Counters: clear wins over a same-cycle delivery; corrected count saturates.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    tot_cnt_d  = tot_cnt_q;

    if (flit_io.clear_counts) begin
      corr_cnt_d = '0;
      tot_cnt_d  = '0;
    end else if (out_fire) begin
      tot_cnt_d = tot_cnt_q + TOT_W'(1);
      if (s2_corr_q && (corr_cnt_q != '1)) begin
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_addr_q  <= '0;
      s2_corr_q  <= 1'b0;
      corr_cnt_q <= '0;
      tot_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_addr_q  <= s2_addr_d;
      s2_corr_q  <= s2_corr_d;
      corr_cnt_q <= corr_cnt_d;
      tot_cnt_q  <= tot_cnt_d;
    end
  end

  assign flit_io.out_valid     = s2_valid_q;
  assign flit_io.out_data      = s2_data_q;
  assign flit_io.out_addr      = s2_addr_q;
  assign flit_io.out_corrected = s2_corr_q;
  assign flit_io.corr_count    = corr_cnt_q;
  assign flit_io.tot_count     = tot_cnt_q;

endmodule
